// File: rtl/led_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// led_sequencer_pkg
// Shared definitions for the LED bar sequencer: sequencer state encoding,
// the width of the lit-LED counter and the default bar length.
// ---------------------------------------------------------------------------
package led_sequencer_pkg;

   // Counter wide enough to hold 0..16 inclusive.
   localparam int LED_CNT_W = 5;

   // Default number of LEDs on the bar.
   localparam int N_LED_DEFAULT = 16;

   typedef enum logic [2:0] {
      IDLE,
      STEP,
      DWELL,
      CHECK,
      SETTLE
   } seq_state_e;

endpackage

// File: rtl/led_sequencer_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a counter debouncer for an asynchronous
// push-button. The debounced level only changes after DB_CYCLES consecutive
// synchronised samples disagree with it.
//
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   btn    - raw, asynchronous button input (active-high)
//   rise   - one-cycle pulse on the cycle the debounced level goes 0 -> 1
// ---------------------------------------------------------------------------
module btn_debounce #(
   parameter int DB_CYCLES = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [1:0]    sync_q, sync_d;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          flip;

   // The counter tracks how many samples in a row have disagreed with the
   // current debounced level; any agreeing sample restarts the run.
   always_comb begin
      sync_d  = {sync_q[0], btn};
      level_d = level_q;
      cnt_d   = cnt_q;
      flip    = 1'b0;
      if (sync_q[1] == level_q) begin
         cnt_d = '0;
      end else if (int'(cnt_q) + 1 >= DB_CYCLES) begin
         flip    = 1'b1;
         level_d = sync_q[1];
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   // Derived only from flops, so the consumer can register it directly and
   // see the rise on the same edge the debounced level flips.
   assign rise = flip & sync_q[1];

endmodule

// File: rtl/led_sequencer.sv
// ---------------------------------------------------------------------------
// led_sequencer
// Drives a thermometer-coded LED bar. On every prescaler tick the lit count
// moves one LED toward the commanded target; on arrival it dwells, pulses
// check for the mode/direction controller, then allows two settle cycles
// for the controller to update its commands. A debounced flick button is
// presented as a held request that is cleared right after check.
//
// Ports:
//   clk       - system clock, all state on the rising edge
//   rst       - asynchronous active-low reset
//   up_down   - 1 = count up, 0 = count down
//   max_num   - target lit count, clamped to N_LED
//   flick_btn - raw asynchronous push-button, active-high
//   check     - registered one-cycle pulse after the dwell ends
//   flick     - registered, latched flick request
//   led       - thermometer code, led[i] = 1 iff i < lit count
// ---------------------------------------------------------------------------
module led_sequencer
   import led_sequencer_pkg::*;
#(
   parameter int TICK_DIV   = 12500000,
   parameter int N_LED      = N_LED_DEFAULT,
   parameter int HOLD_TICKS = 1,
   parameter int DB_CYCLES  = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_down,
   input  logic [LED_CNT_W-1:0] max_num,
   input  logic                 flick_btn,
   output logic                 check,
   output logic                 flick,
   output logic [N_LED-1:0]     led
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = $clog2(HOLD_TICKS + 2);
   localparam logic [LED_CNT_W-1:0] CNT_MAX = LED_CNT_W'(N_LED);

   seq_state_e           state_q, state_d;
   logic [PW-1:0]        presc_q, presc_d;
   logic [LED_CNT_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]        dwell_q, dwell_d;
   logic                 settle_q, settle_d;
   logic                 check_q, check_d;
   logic                 flick_q, flick_d;
   logic [N_LED-1:0]     led_q, led_d;
   logic [LED_CNT_W-1:0] tgt;
   logic                 tick;
   logic                 flick_rise;

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_flick_db (
      .clk   (clk),
      .rst_n (rst),
      .btn   (flick_btn),
      .rise  (flick_rise)
   );

   // Free-running prescaler; tick marks the last cycle of each period.
   always_comb begin
      tick    = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
      tgt     = (max_num > CNT_MAX) ? CNT_MAX : max_num;
   end

   // Sequencer: the count saturates at both rails; reaching either the
   // target or a rail that blocks further movement ends the walk.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dwell_d  = dwell_q;
      settle_d = settle_q;
      case (state_q)
         IDLE: begin
            if (tick) state_d = STEP;
         end
         STEP: begin
            if (tick) begin
               if (cnt_q == tgt) begin
                  state_d = DWELL;
               end else if (up_down && (cnt_q < CNT_MAX)) begin
                  cnt_d = cnt_q + LED_CNT_W'(1);
                  if (cnt_q + LED_CNT_W'(1) == tgt) state_d = DWELL;
               end else if (!up_down && (cnt_q != '0)) begin
                  cnt_d = cnt_q - LED_CNT_W'(1);
                  if (cnt_q - LED_CNT_W'(1) == tgt) state_d = DWELL;
               end else begin
                  state_d = DWELL;
               end
            end
         end
         DWELL: begin
            if (HOLD_TICKS == 0) begin
               state_d = CHECK;
            end else if (tick) begin
               if (int'(dwell_q) + 1 >= HOLD_TICKS) begin
                  state_d = CHECK;
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + DW'(1);
               end
            end
         end
         CHECK: begin
            state_d = SETTLE;
         end
         SETTLE: begin
            if (settle_q) begin
               settle_d = 1'b0;
               state_d  = STEP;
            end else begin
               settle_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs are registered from next-state values so they line up with
   // the state they describe. A new debounced rise beats the post-check clear.
   always_comb begin
      check_d = (state_d == CHECK);
      flick_d = flick_rise | (flick_q & (state_q != CHECK));
      led_d   = '0;
      for (int i = 0; i < N_LED; i++) begin
         led_d[i] = (i < int'(cnt_d));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         presc_q  <= '0;
         cnt_q    <= '0;
         dwell_q  <= '0;
         settle_q <= 1'b0;
         check_q  <= 1'b0;
         flick_q  <= 1'b0;
         led_q    <= '0;
      end else begin
         state_q  <= state_d;
         presc_q  <= presc_d;
         cnt_q    <= cnt_d;
         dwell_q  <= dwell_d;
         settle_q <= settle_d;
         check_q  <= check_d;
         flick_q  <= flick_d;
         led_q    <= led_d;
      end
   end

   assign check = check_q;
   assign flick = flick_q;
   assign led   = led_q;

endmodule

// File: tb/tb_led_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_sequencer
// Self-checking bench for led_sequencer. A behavioural model tracks the lit
// count, the dwell/check timing and the debounced flick request; a compare
// process checks every cycle, and directed scenarios pin literal values.
// ---------------------------------------------------------------------------
module tb_led_sequencer;

   localparam int TICK_DIV   = 4;
   localparam int N_LED      = 16;
   localparam int HOLD_TICKS = 1;
   localparam int DB_CYCLES  = 3;
   localparam int HW         = 2 + DB_CYCLES;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             up_down = 1'b1;
   logic [4:0]       max_num = 5'd5;
   logic             flick_btn = 1'b0;
   logic             check;
   logic             flick;
   logic [N_LED-1:0] led;

   int n_checks = 0;
   int n_errors = 0;

   led_sequencer #(
      .TICK_DIV   (TICK_DIV),
      .N_LED      (N_LED),
      .HOLD_TICKS (HOLD_TICKS),
      .DB_CYCLES  (DB_CYCLES)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .up_down   (up_down),
      .max_num   (max_num),
      .flick_btn (flick_btn),
      .check     (check),
      .flick     (flick),
      .led       (led)
   );

   always #5 clk = ~clk;

   // Behavioural model: cycle stamps and counters instead of a state machine.
   int m_cyc, m_cnt, m_dwell_n, m_holdoff;
   bit m_started, m_dwelling, m_check, m_flick, m_level;
   bit m_hist [HW];

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_cyc = 0; m_cnt = 0; m_dwell_n = 0; m_holdoff = 0;
         m_started = 0; m_dwelling = 0; m_check = 0; m_flick = 0; m_level = 0;
         for (int i = 0; i < HW; i++) m_hist[i] = 0;
      end else begin
         bit tick, was_check, all_diff, rise;
         int tgt;
         tick = ((m_cyc % TICK_DIV) == TICK_DIV - 1);
         m_cyc++;
         was_check = m_check;
         m_check = 0;
         // Button history: index k holds the button sampled k edges ago.
         for (int i = HW - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = flick_btn;
         all_diff = 1;
         for (int i = 2; i < HW; i++) if (m_hist[i] == m_level) all_diff = 0;
         rise = 0;
         if (all_diff) begin
            m_level = !m_level;
            rise = m_level;
         end
         if (rise) m_flick = 1;
         else if (was_check) m_flick = 0;
         // Lit count walk, dwell, check and the three quiet cycles after it.
         if (!m_started) begin
            if (tick) m_started = 1;
         end else if (m_holdoff > 0) begin
            m_holdoff--;
         end else if (m_dwelling) begin
            if (HOLD_TICKS == 0 || tick) begin
               m_dwell_n++;
               if (m_dwell_n >= HOLD_TICKS) begin
                  m_dwelling = 0;
                  m_check = 1;
                  m_holdoff = 3;
               end
            end
         end else if (tick) begin
            tgt = (int'(max_num) > N_LED) ? N_LED : int'(max_num);
            m_dwell_n = 0;
            if (m_cnt == tgt) m_dwelling = 1;
            else if (up_down && m_cnt < N_LED) begin m_cnt++; m_dwelling = (m_cnt == tgt); end
            else if (!up_down && m_cnt > 0) begin m_cnt--; m_dwelling = (m_cnt == tgt); end
            else m_dwelling = 1;
         end
      end
   end

   function automatic logic [31:0] model_led();
      logic [31:0] t;
      t = (32'd1 << m_cnt) - 32'd1;
      return {16'h0, t[N_LED-1:0]};
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
      n_checks++;
      if (actual !== required) begin
         n_errors++;
         $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic wait_for_check(input int budget, input string name);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (check !== 1'b1 && n < budget);
      if (check !== 1'b1) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL %s: no check pulse within %0d cycles, actual=%b required=1", name, budget, check);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check_output("cycle led", 32'(led), model_led());
      check_output("cycle check", 32'(check), 32'(m_check));
      check_output("cycle flick", 32'(flick), 32'(m_flick));
   end

   // Records led changes and check pulses with their cycle stamps.
   int               tb_cyc = 0;
   bit               rec_en = 0;
   logic [N_LED-1:0] last_led = '0;
   logic [N_LED-1:0] trace_v[$];
   int               trace_t[$];
   int               chk_t[$];

   always @(negedge clk) begin
      tb_cyc++;
      if (rec_en && led !== last_led) begin
         trace_v.push_back(led);
         trace_t.push_back(tb_cyc);
      end
      if (rec_en && check) chk_t.push_back(tb_cyc);
      last_led = led;
   end

   task automatic apply_stimulus(input bit ud, input int mx);
      up_down = ud;
      max_num = 5'(mx);
   endtask

   logic [N_LED-1:0] exp_up [5]   = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F};
   logic [N_LED-1:0] exp_down [5] = '{16'h000F, 16'h0007, 16'h0003, 16'h0001, 16'h0000};

   initial begin
      int n;
      int btn_left;
      // Reset state.
      apply_stimulus(1, 5);
      repeat (3) @(negedge clk);
      check_output("reset led", 32'(led), 32'h0);
      check_output("reset check", 32'(check), 32'h0);
      check_output("reset flick", 32'(flick), 32'h0);
      rst = 1'b1;
      rec_en = 1;

      // Count up to 5.
      wait_for_check(200, "up to 5");
      check_output("led at 5", 32'(led), 32'h001F);
      check_output("model cnt 5", 32'(m_cnt), 32'd5);
      @(negedge clk);
      check_output("up trace len", 32'(trace_v.size()), 32'd5);
      for (int i = 0; i < 5 && i < trace_v.size(); i++)
         check_output("up trace", 32'(trace_v[i]), 32'(exp_up[i]));
      for (int i = 1; i < 5 && i < trace_t.size(); i++)
         check_output("step spacing", 32'(trace_t[i] - trace_t[i-1]), 32'(TICK_DIV));
      check_output("up check count", 32'(chk_t.size()), 32'd1);
      if (chk_t.size() > 0 && trace_t.size() == 5)
         check_output("check lag", 32'(chk_t[0] - trace_t[4]), 32'(TICK_DIV));

      // Count down to 0, commanded during settle.
      apply_stimulus(0, 0);
      trace_v.delete(); trace_t.delete(); chk_t.delete();
      wait_for_check(200, "down to 0");
      check_output("led at 0", 32'(led), 32'h0);
      check_output("model cnt 0", 32'(m_cnt), 32'd0);
      @(negedge clk);
      check_output("down trace len", 32'(trace_v.size()), 32'd5);
      for (int i = 0; i < 5 && i < trace_v.size(); i++)
         check_output("down trace", 32'(trace_v[i]), 32'(exp_down[i]));
      check_output("down check count", 32'(chk_t.size()), 32'd1);
      rec_en = 0;

      // Flick: a one-cycle glitch is ignored, a long press latches.
      flick_btn = 1'b1;
      @(negedge clk);
      flick_btn = 1'b0;
      repeat (8) @(negedge clk);
      check_output("glitch flick", 32'(flick), 32'h0);
      check_output("model glitch", 32'(m_flick), 32'h0);
      flick_btn = 1'b1;
      fork
         begin
            repeat (10) @(negedge clk);
            flick_btn = 1'b0;
         end
      join_none
      repeat (5) @(negedge clk);
      check_output("flick latched", 32'(flick), 32'h1);
      check_output("model flick", 32'(m_flick), 32'h1);
      if (check !== 1'b1) wait_for_check(100, "flick check");
      check_output("flick at check", 32'(flick), 32'h1);
      @(negedge clk);
      check_output("flick cleared", 32'(flick), 32'h0);

      // Target above the bar length saturates at 16.
      apply_stimulus(1, 20);
      wait_for_check(300, "saturate");
      check_output("led full", 32'(led), 32'hFFFF);
      check_output("model cnt 16", 32'(m_cnt), 32'd16);
      wait_for_check(100, "no wrap");
      check_output("led still full", 32'(led), 32'hFFFF);

      // Asynchronous reset mid-count, then restart from zero.
      rst = 1'b0;
      apply_stimulus(1, 10);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (led !== 16'h007F && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_output("reach 7", 32'(led), 32'h007F);
      #1 rst = 1'b0;
      #1;
      check_output("async led", 32'(led), 32'h0);
      check_output("async check", 32'(check), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (led === '0 && n < 50);
      check_output("restart latency", 32'(n), 32'(2 * TICK_DIV));
      check_output("restart led", 32'(led), 32'h0001);

      // Randomised run checked by the per-cycle compare.
      btn_left = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) up_down = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) max_num = 5'($urandom_range(0, 31));
         if (btn_left == 0) begin
            flick_btn = 1'($urandom_range(0, 1));
            btn_left = $urandom_range(1, 8);
         end else begin
            btn_left--;
         end
         if ($urandom_range(0, 599) == 0) begin
            #($urandom_range(1, 3));
            rst = 1'b0;
            #1;
            check_output("rand async led", 32'(led), 32'h0);
            @(negedge clk);
            rst = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
